// File: rtl/frame_buf_pkg.sv
// frame_buf_pkg: state encoding and signal-polarity constants shared by the
// frame-buffer read path, plus a helper for occupancy counter widths.
package frame_buf_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRIME  = 2'd1,
      STREAM = 2'd2
   } state_t;

   localparam logic ASSERT_L   = 1'b0;
   localparam logic DEASSERT_L = 1'b1;
   localparam logic ASSERT_H   = 1'b1;
   localparam logic DEASSERT_H = 1'b0;

   // Counter width able to hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/frame_rd_stream_if.sv
// frame_rd_stream_if: memory-side, pixel-side and status signals of
// frame_rd_stream. The slave modport is the streamer's view; the master
// modport is the surrounding system's view. underrun_cnt exists only when
// FRAME_RD_STATS_EN is defined.
//
// Handshakes: a read counts as issued on every cycle with
// avl_read_req && avl_ready; a returned word is taken on every cycle with
// avl_rdata_valid high (no back-pressure on returns); a pixel transfers on
// every cycle with pix_valid && pix_rdy, and pix_valid/pix_data never depend
// on pix_rdy. rd_en is active-low and only advises the frame buffer.
interface frame_rd_stream_if
   import frame_buf_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16
);
   localparam int CW = cnt_width(FIFO_DEPTH);

   logic                  ram_rdy;
   logic                  avl_ready;
   logic                  avl_read_req;
   logic                  avl_rdata_valid;
   logic [DATA_WIDTH-1:0] avl_rdata;
   logic                  rd_en;
   logic                  pix_rdy;
   logic                  pix_valid;
   logic [DATA_WIDTH-1:0] pix_data;
   logic [CW-1:0]         fifo_count;
   logic                  overflow;
   logic                  underrun;
   state_t                state;
`ifdef FRAME_RD_STATS_EN
   logic [15:0]           underrun_cnt;
`endif

   modport slave (
`ifdef FRAME_RD_STATS_EN
      output underrun_cnt,
`endif
      input  ram_rdy, avl_ready, avl_read_req, avl_rdata_valid, avl_rdata, pix_rdy,
      output rd_en, pix_valid, pix_data, fifo_count, overflow, underrun, state
   );

   modport master (
`ifdef FRAME_RD_STATS_EN
      input  underrun_cnt,
`endif
      output ram_rdy, avl_ready, avl_read_req, avl_rdata_valid, avl_rdata, pix_rdy,
      input  rd_en, pix_valid, pix_data, fifo_count, overflow, underrun, state
   );

endinterface

// File: rtl/rd_fifo_mem.sv
// rd_fifo_mem: return-buffer storage with wrapping read/write pointers.
// Show-ahead: head_o is the word at the read pointer with no register stage.
// The owner guarantees push_i is never raised while the buffer is full unless
// pop_i is raised in the same cycle.
module rd_fifo_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] head_o
);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;

   // Pointers advance by one and wrap naturally at the power-of-two depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
   end

   // Pointer registers; reset discards whatever the storage still holds.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write; contents are meaningless until covered by the occupancy count.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/frame_rd_stream.sv
// frame_rd_stream: turns Avalon read returns from a frame buffer into a
// pixel stream. Tracks outstanding reads, throttles the frame buffer through
// the active-low rd_en credit signal, primes the return buffer before
// streaming and flags overflow/underrun. Optional FRAME_RD_STATS_EN adds a
// saturating count of empty-buffer cycles while streaming.
module frame_rd_stream
   import frame_buf_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int RD_SLACK   = 4,
   parameter int PRIME_LVL  = 8
) (
   input logic              clk,
   input logic              reset,
   frame_rd_stream_if.slave bus
);
   localparam int CW = cnt_width(FIFO_DEPTH);
   localparam int SW = CW + 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] PRIME_C   = CW'(PRIME_LVL);
   localparam logic [CW-1:0] OUTST_MAX = {CW{1'b1}};
   localparam logic [SW-1:0] CREDIT_C  = SW'(FIFO_DEPTH - RD_SLACK);

   state_t                state_q, state_d;
   logic [CW-1:0]         count_q, count_d;
   logic [CW-1:0]         outst_q, outst_d;
   logic                  ovf_q, ovf_d;
   logic                  unr_q, unr_d;
   logic                  issue, ret, pop, push_ok, stray_ret;
   logic                  pix_valid_w, stream_empty;
   logic [SW-1:0]         credit_sum;
   logic [DATA_WIDTH-1:0] head;

   assign issue        = bus.avl_read_req && bus.avl_ready;
   assign ret          = bus.avl_rdata_valid;
   assign pix_valid_w  = (state_q == STREAM) && (count_q != '0);
   assign stream_empty = (state_q == STREAM) && (count_q == '0);
   assign pop          = pix_valid_w && bus.pix_rdy;
   // A full buffer still accepts a return when the head leaves the same cycle.
   assign push_ok      = ret && ((count_q != DEPTH_C) || pop);
   assign stray_ret    = ret && (outst_q == '0);
   assign credit_sum   = {1'b0, count_q} + {1'b0, outst_q};

   rd_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_mem (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push_ok),
      .push_data_i (bus.avl_rdata),
      .pop_i       (pop),
      .head_o      (head)
   );

   // Next state: prime after calibration, stream once primed; losing ram_rdy always idles.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = PRIME;
         PRIME:   if (count_q >= PRIME_C) state_d = STREAM;
         STREAM:  state_d = STREAM;
         default: state_d = IDLE;
      endcase
      if (!bus.ram_rdy) state_d = IDLE;
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Outstanding reads, occupancy and sticky error flags.
   always_comb begin
      outst_d = outst_q;
      if (issue && !ret) begin
         if (outst_q != OUTST_MAX) outst_d = outst_q + CW'(1);
      end else if (!issue && ret) begin
         if (outst_q != '0) outst_d = outst_q - CW'(1);
      end
      count_d = count_q;
      if (push_ok && !pop)      count_d = count_q + CW'(1);
      else if (!push_ok && pop) count_d = count_q - CW'(1);
      ovf_d = ovf_q || stray_ret || (ret && !push_ok);
      unr_d = unr_q || stream_empty;
   end

   // Counter and flag registers; kept across IDLE, cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         outst_q <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unr_q   <= 1'b0;
      end else begin
         outst_q <= outst_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unr_q   <= unr_d;
      end
   end

`ifdef FRAME_RD_STATS_EN
   logic [15:0] ucnt_q, ucnt_d;

   // Saturating count of streaming cycles that find the buffer empty.
   always_comb begin
      ucnt_d = ucnt_q;
      if (stream_empty && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
   end

   // Statistics register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ucnt_q <= '0;
      else        ucnt_q <= ucnt_d;
   end

   assign bus.underrun_cnt = ucnt_q;
`endif

   assign bus.rd_en      = ((state_q != IDLE) && bus.ram_rdy && (credit_sum <= CREDIT_C))
                           ? ASSERT_L : DEASSERT_L;
   assign bus.pix_valid  = pix_valid_w ? ASSERT_H : DEASSERT_H;
   assign bus.pix_data   = pix_valid_w ? head : '0;
   assign bus.fifo_count = count_q;
   assign bus.overflow   = ovf_q;
   assign bus.underrun   = unr_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_frame_rd_stream.sv
// tb_frame_rd_stream: table-driven priming sequence, directed corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_frame_rd_stream;
   import frame_buf_pkg::*;

   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int SLACK = 4;
   localparam int PLVL  = 8;
   localparam int CW    = 5;
   localparam int NV    = 20;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   frame_rd_stream_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

   frame_rd_stream #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH),
      .RD_SLACK   (SLACK),
      .PRIME_LVL  (PLVL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- reference model / scoreboard ----------------
   logic [DW-1:0] exp_q[$];
   int            m_outst;
   state_t        m_state;
   bit            m_ovf, m_unr;
   int            m_ucnt;
   int            n_tests = 0;
   int            n_fail  = 0;

   typedef struct {
      bit            rr, rq, rv, pr;
      logic [CW-1:0] exp_cnt;
      bit            exp_pv, exp_rd;
   } vec_t;
   vec_t tbl[NV];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_rd_en(input bit rr);
      return !((m_state != IDLE) && rr && (exp_q.size() + m_outst <= DEPTH - SLACK));
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_outst = 0;
      m_state = IDLE;
      m_ovf   = 0;
      m_unr   = 0;
      m_ucnt  = 0;
   endtask

   // Compare every output against the model for the current (pre-edge) cycle.
   task automatic model_check();
      bit pv;
      pv = (m_state == STREAM) && (exp_q.size() != 0);
      check("pix_valid", bus.pix_valid, pv);
      if (pv) check("pix_data", bus.pix_data, exp_q[0]);
      else    check("pix_data_idle", bus.pix_data, 0);
      check("rd_en", bus.rd_en, exp_rd_en(bus.ram_rdy));
      check("fifo_count", bus.fifo_count, exp_q.size());
      check("overflow", bus.overflow, m_ovf);
      check("underrun", bus.underrun, m_unr);
      check("state", bus.state, m_state);
`ifdef FRAME_RD_STATS_EN
      check("underrun_cnt", bus.underrun_cnt, m_ucnt);
`endif
   endtask

   // Advance the model by one clock using the inputs that were applied.
   task automatic model_update();
      int     sz;
      bit     pop, issue, ret;
      state_t nxt;
      sz    = exp_q.size();
      pop   = (m_state == STREAM) && (sz != 0) && bus.pix_rdy;
      issue = bus.avl_read_req && bus.avl_ready;
      ret   = bus.avl_rdata_valid;
      if (ret && m_outst == 0) m_ovf = 1;
      if (issue && !ret && m_outst < 31) m_outst++;
      else if (ret && !issue && m_outst > 0) m_outst--;
      if (m_state == STREAM && sz == 0) begin
         m_unr = 1;
         if (m_ucnt < 65535) m_ucnt++;
      end
      if (!bus.ram_rdy)                    nxt = IDLE;
      else if (m_state == IDLE)            nxt = PRIME;
      else if (m_state == PRIME && sz >= PLVL) nxt = STREAM;
      else                                 nxt = m_state;
      if (pop) void'(exp_q.pop_front());
      if (ret) begin
         if (sz < DEPTH || pop) exp_q.push_back(bus.avl_rdata);
         else m_ovf = 1;
      end
      m_state = nxt;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input bit rr, input bit ar, input bit rq, input bit rv,
                        input logic [DW-1:0] d, input bit pr);
      bus.ram_rdy         = rr;
      bus.avl_ready       = ar;
      bus.avl_read_req    = rq;
      bus.avl_rdata_valid = rv;
      bus.avl_rdata       = d;
      bus.pix_rdy         = pr;
   endtask

   task automatic idle(input bit rr, input bit pr);
      drive(rr, 1'b1, 1'b0, 1'b0, '0, pr);
   endtask

   task automatic run_cycle();
      #1;
      model_check();
      @(posedge clk);
      #1;
      model_update();
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      #1;
      check("rst_fifo_count", bus.fifo_count, 0);
      check("rst_rd_en", bus.rd_en, 1);
      check("rst_pix_valid", bus.pix_valid, 0);
      check("rst_pix_data", bus.pix_data, 0);
      check("rst_overflow", bus.overflow, 0);
      check("rst_underrun", bus.underrun, 0);
      check("rst_state", bus.state, IDLE);
      model_reset();
      idle(1'b0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      bit rr, ar, rq, rv, pr;

      // Priming table: 8 reads issued, 8 returns, then streaming begins one cycle after count hits 8.
      tbl[0] = '{rr:1, rq:0, rv:0, pr:1, exp_cnt:0, exp_pv:0, exp_rd:1};
      for (int i = 1; i <= 8; i++)
         tbl[i] = '{rr:1, rq:1, rv:0, pr:1, exp_cnt:0, exp_pv:0, exp_rd:0};
      for (int i = 9; i <= 16; i++)
         tbl[i] = '{rr:1, rq:0, rv:1, pr:1, exp_cnt:CW'(i - 9), exp_pv:0, exp_rd:0};
      tbl[17] = '{rr:1, rq:0, rv:0, pr:1, exp_cnt:8, exp_pv:0, exp_rd:0};
      tbl[18] = '{rr:1, rq:0, rv:0, pr:1, exp_cnt:8, exp_pv:1, exp_rd:0};
      tbl[19] = '{rr:1, rq:0, rv:0, pr:1, exp_cnt:7, exp_pv:1, exp_rd:0};

      idle(1'b0, 1'b0);
      #2;
      apply_reset();

      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].rr, 1'b1, tbl[i].rq, tbl[i].rv, DW'(32'hA000_0000 + i), tbl[i].pr);
         #1;
         check($sformatf("tbl%0d_count", i), bus.fifo_count, tbl[i].exp_cnt);
         check($sformatf("tbl%0d_pix_valid", i), bus.pix_valid, tbl[i].exp_pv);
         check($sformatf("tbl%0d_rd_en", i), bus.rd_en, tbl[i].exp_rd);
         run_cycle();
      end

      // Drain to 5 buffered words mid-stream, then reset asynchronously.
      for (int k = 0; k < 10 && exp_q.size() > 5; k++) begin
         idle(1'b1, 1'b1);
         run_cycle();
      end
      check("pre_rst_count", bus.fifo_count, 5);
      check("pre_rst_state", bus.state, STREAM);
      #2;
      apply_reset();

      // A return with nothing outstanding is flagged.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h5757_0001, 1'b0);
      run_cycle();
      check("stray_overflow", bus.overflow, 1);
      check("stray_count", bus.fifo_count, 1);
      idle(1'b1, 1'b0);
      run_cycle();
      check("stray_overflow_sticky", bus.overflow, 1);
      apply_reset();

      // Credit throttling and overflow on the 17th return.
      idle(1'b1, 1'b0);
      run_cycle();
      for (int i = 1; i <= 17; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
         #1;
         if (i == 13) check("credit_sum12_rd_en", bus.rd_en, 0);
         if (i == 14) check("credit_sum13_rd_en", bus.rd_en, 1);
         run_cycle();
      end
      for (int i = 1; i <= 17; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b1, $urandom(), 1'b0);
         #1;
         check("count_le_depth", bus.fifo_count <= DEPTH, 1);
         if (i == 17) begin
            check("pre_drop_count", bus.fifo_count, 16);
            check("pre_drop_overflow", bus.overflow, 0);
         end
         run_cycle();
      end
      check("drop_count", bus.fifo_count, 16);
      check("drop_overflow", bus.overflow, 1);
      for (int i = 0; i < 3; i++) begin
         idle(1'b1, 1'b0);
         run_cycle();
      end
      check("overflow_sticky", bus.overflow, 1);

      // Drain everything, then keep pulling with no returns: underrun.
      for (int i = 0; i < 16; i++) begin
         idle(1'b1, 1'b1);
         run_cycle();
      end
      check("underrun_before_empty", bus.underrun, 0);
      for (int j = 0; j < 4; j++) begin
         idle(1'b1, 1'b1);
         run_cycle();
         check("underrun_set", bus.underrun, 1);
         check("underrun_stays_stream", bus.state, STREAM);
`ifdef FRAME_RD_STATS_EN
         check("underrun_cnt_step", bus.underrun_cnt, j + 1);
`endif
      end
      apply_reset();

      // Simultaneous push/pop across the write-pointer wrap.
      idle(1'b1, 1'b0);
      run_cycle();
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
         run_cycle();
      end
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b1, $urandom(), 1'b0);
         run_cycle();
      end
      idle(1'b1, 1'b0);
      run_cycle();
      check("wrap_state", bus.state, STREAM);
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b1, $urandom(), 1'b1);
         #1;
         check("wrap_count", bus.fifo_count, 8);
         check("wrap_overflow", bus.overflow, 0);
         run_cycle();
      end
      for (int i = 0; i < 10; i++) begin
         idle(1'b1, 1'b1);
         run_cycle();
      end
      apply_reset();

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         rr = ($urandom_range(0, 99) != 0);
         ar = ($urandom_range(0, 3) != 0);
         rq = (!exp_rd_en(rr) && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 199) == 0);
         rv = ((m_outst > 0) && ($urandom_range(0, 2) != 0)) || ($urandom_range(0, 299) == 0);
         pr = ($urandom_range(0, 3) != 0);
         drive(rr, ar, rq, rv, $urandom(), pr);
         run_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
